spi_tx16: RTL and testbench

- SPI master transmitter: sends one 16-bit word per CS frame, MSB first.
- Wire format matches spi_rx16: CS active low, SCLK idles high, MOSI changes on the falling edge, the receiver samples on the rising edge.
- Sits in the system clock domain and generates SCLK by division.
- The host side is a valid/ready word interface.

---
 rtl/spi_tx16_pkg.sv | 29 ++
 rtl/spi_tx16_phase_cnt.sv | 26 ++
 rtl/spi_tx16.sv | 162 ++++++++++++++++
 tb/tb_spi_tx16.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_tx16_pkg.sv
// rtl/spi_tx16_pkg.sv - shared state encoding, frame size and default timing for spi_tx16
package spi_tx16_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    HOLD,
    GAP
  } state_t;

  localparam int FRAME_BITS   = 16;
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_CS_IDLE  = 2;

  // Counters are loaded with (length - 1), so $clog2 of the longest length suffices.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/spi_tx16_phase_cnt.sv
// rtl/spi_tx16_phase_cnt.sv - loadable down-counter with terminal-count flag
module spi_tx16_phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/spi_tx16.sv
// rtl/spi_tx16.sv - SPI master transmitter, one 16-bit MSB-first word per CS frame (mode 3)
// Define SPI_TX16_MISO_EN to add the full-duplex receive path (spi_miso, rx_data).
module spi_tx16
  import spi_tx16_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int CS_IDLE  = DEF_CS_IDLE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  spi_cs,
  output logic                  spi_clk,
  output logic                  spi_mosi
`ifdef SPI_TX16_MISO_EN
  ,
  input  logic                  spi_miso,
  output logic [FRAME_BITS-1:0] rx_data
`endif
);

  localparam int CNT_W = cnt_width(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_HALF  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_IDLE  = CNT_W'(CS_IDLE - 1);

  state_t                state, state_n;
  logic [FRAME_BITS-1:0] shift_q, shift_n;
  logic [BIT_W-1:0]      bit_cnt, bit_n;
  logic                  cs_n, sclk_n, mosi_n, done_n;
  logic                  ph_load;
  logic [CNT_W-1:0]      ph_val;
  logic                  ph_tc;

  spi_tx16_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_val),
    .tc       (ph_tc)
  );

  assign tx_ready = (state == IDLE) && !reset;
  assign busy     = !tx_ready && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shift_q  <= '0;
      bit_cnt  <= '0;
      spi_cs   <= 1'b1;
      spi_clk  <= 1'b1;
      spi_mosi <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shift_q  <= shift_n;
      bit_cnt  <= bit_n;
      spi_cs   <= cs_n;
      spi_clk  <= sclk_n;
      spi_mosi <= mosi_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    shift_n = shift_q;
    bit_n   = bit_cnt;
    cs_n    = spi_cs;
    sclk_n  = spi_clk;
    mosi_n  = spi_mosi;
    done_n  = 1'b0;
    ph_load = 1'b0;
    ph_val  = '0;
    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          shift_n = tx_data;
          bit_n   = BIT_W'(FRAME_BITS - 1);
          cs_n    = 1'b0;
          sclk_n  = 1'b1;
          mosi_n  = tx_data[FRAME_BITS-1];
          ph_load = 1'b1;
          ph_val  = LD_SETUP;
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (ph_tc) begin
          sclk_n  = 1'b0;
          ph_load = 1'b1;
          ph_val  = LD_HALF;
          state_n = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (ph_tc) begin
          sclk_n  = 1'b1;
          ph_load = 1'b1;
          ph_val  = LD_HALF;
          state_n = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (ph_tc) begin
          ph_load = 1'b1;
          if (bit_cnt == '0) begin
            ph_val  = LD_HOLD;
            state_n = HOLD;
          end else begin
            // Rotate rather than shift so the next bit is always at [FRAME_BITS-2].
            shift_n = {shift_q[FRAME_BITS-2:0], shift_q[FRAME_BITS-1]};
            mosi_n  = shift_q[FRAME_BITS-2];
            bit_n   = bit_cnt - BIT_W'(1);
            sclk_n  = 1'b0;
            ph_val  = LD_HALF;
            state_n = SHIFT_LO;
          end
        end
      end
      HOLD: begin
        if (ph_tc) begin
          cs_n    = 1'b1;
          mosi_n  = 1'b0;
          done_n  = 1'b1;
          ph_load = 1'b1;
          ph_val  = LD_IDLE;
          state_n = GAP;
        end
      end
      GAP: begin
        if (ph_tc) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef SPI_TX16_MISO_EN
  logic [FRAME_BITS-1:0] rx_shift;

  // Sample on the last LOW cycle, i.e. the edge that raises spi_clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shift <= '0;
      rx_data  <= '0;
    end else begin
      if (state == SHIFT_LO && ph_tc) rx_shift <= {rx_shift[FRAME_BITS-2:0], spi_miso};
      if (state == HOLD && ph_tc)     rx_data  <= rx_shift;
    end
  end
`endif

endmodule

// File: tb/tb_spi_tx16.sv
// tb/tb_spi_tx16.sv - self-checking bench for spi_tx16 with a behavioural SPI receiver model
module tb_spi_tx16;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_IDLE  = 2;
  localparam int T_DONE   = 1 + CS_SETUP + 2 * 16 * CLK_DIV + CS_HOLD;
  localparam int T_READY  = T_DONE + CS_IDLE;
  localparam int T1_DONE  = 1 + CS_SETUP + 2 * 16 * 1 + CS_HOLD;
  localparam int T1_READY = T1_DONE + CS_IDLE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = 16'h0;
  logic        tx_ready, busy, done, spi_cs, spi_clk, spi_mosi;
  logic        t1_valid = 1'b0;
  logic [15:0] t1_data = 16'h0;
  logic        t1_ready, t1_busy, t1_done, t1_cs, t1_clk, t1_mosi;
`ifdef SPI_TX16_MISO_EN
  logic [15:0] rx_data, t1_rx;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_tx16 #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .busy(busy), .done(done), .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi)
`ifdef SPI_TX16_MISO_EN
    , .spi_miso(spi_mosi), .rx_data(rx_data)
`endif
  );

  spi_tx16 #(.CLK_DIV(1), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut1 (
    .clk(clk), .reset(reset), .tx_valid(t1_valid), .tx_ready(t1_ready), .tx_data(t1_data),
    .busy(t1_busy), .done(t1_done), .spi_cs(t1_cs), .spi_clk(t1_clk), .spi_mosi(t1_mosi)
`ifdef SPI_TX16_MISO_EN
    , .spi_miso(t1_mosi), .rx_data(t1_rx)
`endif
  );

  // Receiver model: mode 3 slave sampling MOSI on each SCLK rise while CS is low.
  logic        m_pclk = 1'b1;
  logic        m_pcs  = 1'b1;
  logic [15:0] m_word = 16'h0;
  int          m_rises = 0;
  int          m_high_len = 0;
  logic [15:0] m_words[$];
  int          m_counts[$];
  int          m_gaps[$];
  logic [15:0] m_rx[$];

  always @(negedge clk) begin
    if (m_pcs && !spi_cs) begin
      m_rises = 0;
      m_gaps.push_back(m_high_len);
    end
    if (spi_cs) m_high_len++;
    else m_high_len = 0;
    if (!m_pclk && spi_clk && !spi_cs) begin
      m_word = {m_word[14:0], spi_mosi};
      m_rises++;
    end
    if (done) begin
      m_words.push_back(m_word);
      m_counts.push_back(m_rises);
`ifdef SPI_TX16_MISO_EN
      m_rx.push_back(rx_data);
`endif
    end
    m_pclk = spi_clk;
    m_pcs  = spi_cs;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_model();
    m_words.delete();
    m_counts.delete();
    m_gaps.delete();
    m_rx.delete();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 400 && !tx_ready; i++) tick();
  endtask

  // Caller must be at a point where tx_ready is high; the next edge accepts w.
  task automatic run_frame(input logic [15:0] w, output int done_rel, output int ready_rel,
                           output int fall_rel, output logic cs1, output logic mosi1);
    done_rel = -1; ready_rel = -1; fall_rel = -1;
    tx_data = w;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data = 16'($urandom);
    cs1 = spi_cs;
    mosi1 = spi_mosi;
    for (int rel = 1; rel < 400 && ready_rel < 0; rel++) begin
      if (fall_rel < 0 && !spi_clk) fall_rel = rel;
      if (done) done_rel = rel;
      if (done_rel >= 0 && tx_ready) ready_rel = rel;
      if (ready_rel < 0) tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_valid = 1'b1;
    tx_data = 16'hFFFF;
    repeat (3) tick();
    total++; if (spi_cs !== 1'b1)   begin bad++; $display("FAIL rst_cs got=%b exp=1", spi_cs); end
    total++; if (spi_clk !== 1'b1)  begin bad++; $display("FAIL rst_clk got=%b exp=1", spi_clk); end
    total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi got=%b exp=0", spi_mosi); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", tx_ready); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
    tx_valid = 1'b0;
    reset = 1'b0;
    clear_model();
    tick();
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rel_ready got=%b exp=1", tx_ready); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rel_busy got=%b exp=0", busy); end
    total++; if (spi_cs !== 1'b1)   begin bad++; $display("FAIL rel_cs got=%b exp=1", spi_cs); end
  endtask

  task automatic test_single();
    int d, r, f; logic c1, m1;
    clear_model();
    wait_ready();
    run_frame(16'hA55A, d, r, f, c1, m1);
    total++; if (c1 !== 1'b0)     begin bad++; $display("FAIL single_cs1 got=%b exp=0", c1); end
    total++; if (m1 !== 1'b1)     begin bad++; $display("FAIL single_mosi1 got=%b exp=1", m1); end
    total++; if (f != 1 + CS_SETUP) begin bad++; $display("FAIL single_fall got=%0d exp=%0d", f, 1 + CS_SETUP); end
    total++; if (d != T_DONE)     begin bad++; $display("FAIL single_done got=%0d exp=%0d", d, T_DONE); end
    total++; if (r != T_READY)    begin bad++; $display("FAIL single_ready got=%0d exp=%0d", r, T_READY); end
    total++; if (m_words.size() != 1) begin bad++; $display("FAIL single_ndone got=%0d exp=1", m_words.size()); end
    else begin
      total++; if (m_words[0] !== 16'hA55A) begin bad++; $display("FAIL single_word got=%h exp=a55a", m_words[0]); end
      total++; if (m_counts[0] != 16) begin bad++; $display("FAIL single_rises got=%0d exp=16", m_counts[0]); end
    end
  endtask

  task automatic test_random_frames();
    int d, r, f; logic c1, m1; logic [15:0] w;
    for (int n = 0; n < 4; n++) begin
      clear_model();
      wait_ready();
      w = 16'($urandom);
      run_frame(w, d, r, f, c1, m1);
      total++; if (m1 !== w[15]) begin bad++; $display("FAIL rand_mosi1 got=%b exp=%b", m1, w[15]); end
      total++; if (d != T_DONE)  begin bad++; $display("FAIL rand_done got=%0d exp=%0d", d, T_DONE); end
      total++; if (m_words.size() != 1 || m_words[0] !== w)
        begin bad++; $display("FAIL rand_word got=%h exp=%h", (m_words.size() > 0) ? m_words[0] : 16'hxxxx, w); end
    end
  endtask

  task automatic test_sweep();
    logic [15:0] words[$];
    words = '{16'h0000, 16'h5555, 16'hAAAA, 16'hFFFF, 16'h1000, 16'h0001, 16'h1001};
    words.push_back(16'($urandom));
    clear_model();
    wait_ready();
    tx_valid = 1'b1;
    foreach (words[i]) begin
      tx_data = words[i];
      for (int k = 0; k < 400 && !tx_ready; k++) tick();
      tick();
    end
    tx_valid = 1'b0;
    wait_ready();
    total++; if (m_words.size() != words.size())
      begin bad++; $display("FAIL sweep_count got=%0d exp=%0d", m_words.size(), words.size()); end
    else begin
      foreach (words[i]) begin
        total++; if (m_words[i] !== words[i]) begin bad++; $display("FAIL sweep_word%0d got=%h exp=%h", i, m_words[i], words[i]); end
        total++; if (m_counts[i] != 16) begin bad++; $display("FAIL sweep_rises%0d got=%0d exp=16", i, m_counts[i]); end
      end
    end
    // CS stays high from the done cycle through the accept cycle: CS_IDLE + 1 cycles.
    for (int i = 1; i < m_gaps.size(); i++) begin
      total++; if (m_gaps[i] != CS_IDLE + 1) begin bad++; $display("FAIL sweep_gap%0d got=%0d exp=%0d", i, m_gaps[i], CS_IDLE + 1); end
    end
  endtask

  task automatic test_busy_reject();
    int wait_n;
    clear_model();
    wait_ready();
    tx_data = 16'h0F0F;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    wait_n = $urandom_range(100, 10);
    repeat (wait_n) tick();
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b exp=0", tx_ready); end
    tx_data = 16'h1234;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    wait_ready();
    repeat (10) tick();
    total++; if (m_words.size() != 1) begin bad++; $display("FAIL busy_ndone got=%0d exp=1", m_words.size()); end
    else begin
      total++; if (m_words[0] !== 16'h0F0F) begin bad++; $display("FAIL busy_word got=%h exp=0f0f", m_words[0]); end
    end
    total++; if (m_gaps.size() != 1) begin bad++; $display("FAIL busy_frames got=%0d exp=1", m_gaps.size()); end
  endtask

  task automatic test_reset_mid();
    int d, r, f; logic c1, m1;
    clear_model();
    wait_ready();
    tx_data = 16'($urandom);
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (59) tick();
    reset = 1'b1;
    tick();
    total++; if (spi_cs !== 1'b1)   begin bad++; $display("FAIL mid_cs got=%b exp=1", spi_cs); end
    total++; if (spi_clk !== 1'b1)  begin bad++; $display("FAIL mid_clk got=%b exp=1", spi_clk); end
    total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL mid_mosi got=%b exp=0", spi_mosi); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    reset = 1'b0;
    repeat (5) tick();
    total++; if (m_words.size() != 0) begin bad++; $display("FAIL mid_done got=%0d exp=0", m_words.size()); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", tx_ready); end
    clear_model();
    run_frame(16'h8001, d, r, f, c1, m1);
    total++; if (d != T_DONE) begin bad++; $display("FAIL after_done got=%0d exp=%0d", d, T_DONE); end
    total++; if (m_words.size() != 1 || m_words[0] !== 16'h8001)
      begin bad++; $display("FAIL after_word got=%h exp=8001", (m_words.size() > 0) ? m_words[0] : 16'hxxxx); end
  endtask

  task automatic test_clk_div1();
    logic [15:0] w, got; int done_rel, ready_rel, rises; logic pclk;
`ifdef SPI_TX16_MISO_EN
    logic [15:0] rx_at_done;
`endif
    for (int n = 0; n < 3; n++) begin
      w = (n == 0) ? 16'h3C96 : 16'($urandom);
      got = 16'h0; rises = 0; done_rel = -1; ready_rel = -1; pclk = 1'b1;
      for (int i = 0; i < 100 && !t1_ready; i++) tick();
      t1_data = w;
      t1_valid = 1'b1;
      tick();
      t1_valid = 1'b0;
      for (int rel = 1; rel < 200 && ready_rel < 0; rel++) begin
        if (!pclk && t1_clk && !t1_cs) begin got = {got[14:0], t1_mosi}; rises++; end
        if (t1_done) begin
          done_rel = rel;
`ifdef SPI_TX16_MISO_EN
          rx_at_done = t1_rx;
`endif
        end
        if (done_rel >= 0 && t1_ready) ready_rel = rel;
        pclk = t1_clk;
        if (ready_rel < 0) tick();
      end
      total++; if (got !== w)   begin bad++; $display("FAIL div1_word got=%h exp=%h", got, w); end
      total++; if (rises != 16) begin bad++; $display("FAIL div1_rises got=%0d exp=16", rises); end
      total++; if (done_rel != T1_DONE)   begin bad++; $display("FAIL div1_done got=%0d exp=%0d", done_rel, T1_DONE); end
      total++; if (ready_rel != T1_READY) begin bad++; $display("FAIL div1_ready got=%0d exp=%0d", ready_rel, T1_READY); end
`ifdef SPI_TX16_MISO_EN
      total++; if (rx_at_done !== w) begin bad++; $display("FAIL div1_rx got=%h exp=%h", rx_at_done, w); end
`endif
    end
  endtask

`ifdef SPI_TX16_MISO_EN
  task automatic test_duplex();
    int d, r, f; logic c1, m1;
    clear_model();
    wait_ready();
    run_frame(16'h3C96, d, r, f, c1, m1);
    total++; if (m_rx.size() != 1 || m_rx[0] !== 16'h3C96)
      begin bad++; $display("FAIL duplex_rx got=%h exp=3c96", (m_rx.size() > 0) ? m_rx[0] : 16'hxxxx); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_random_frames();
    test_sweep();
    test_busy_reject();
    test_reset_mid();
    test_clk_div1();
`ifdef SPI_TX16_MISO_EN
    test_duplex();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
